// File: rtl/mmio_store_ctrl_if.sv
// AXI-Lite write-channel bundle (AW, W, B) between mmio_store_ctrl (master) and the MMIO fabric (slave).
interface mmio_store_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              m_awvalid;
    logic              m_awready;
    logic [ADDR_W-1:0] m_awaddr;
    logic [2:0]        m_awprot;

    logic              m_wvalid;
    logic              m_wready;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;

    logic              m_bvalid;
    logic              m_bready;
    logic [1:0]        m_bresp;

    modport master (
        output m_awvalid, m_awaddr, m_awprot,
        output m_wvalid, m_wdata, m_wstrb,
        output m_bready,
        input  m_awready, m_wready, m_bvalid, m_bresp
    );

    modport slave (
        input  m_awvalid, m_awaddr, m_awprot,
        input  m_wvalid, m_wdata, m_wstrb,
        input  m_bready,
        output m_awready, m_wready, m_bvalid, m_bresp
    );
endinterface

// File: rtl/mmio_store_ctrl.sv
// Store-side MMIO controller: buffers memory-stage stores in a FIFO and issues each as one AXI-Lite write.
// Define MMIO_STORE_ERR_EN to add the sticky `err` output (bad write response or discarded misaligned store).
module mmio_store_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [2:0]        req_funct3,
    output logic              req_ready,
    output logic              stall,
    output logic              idle,
`ifdef MMIO_STORE_ERR_EN
    output logic              err,
`endif
    mmio_store_ctrl_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [1:0]        size;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT_AW,
        S_WAIT_W,
        S_RESP
    } state_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              load;

    entry_t            head;
    logic              head_misaligned;
    logic [3:0]        head_strb;
    logic [31:0]       head_wdata;

    state_t            state;
    state_t            state_nxt;

    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign stall     = req_valid && full;
    // Push looks only at `full`, never at a same-cycle pop, to keep req_ready off the FSM path.
    assign push      = req_valid && !full;
    assign idle      = empty && (state == S_IDLE);

    // ------------------------------------------------------------------
    // Store FIFO
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; `count` alone decides which entries are live.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= '{addr: req_addr, data: req_data, size: req_funct3[1:0]};
    end

    assign head = mem[rd_ptr];

    // ------------------------------------------------------------------
    // Lane formatting and alignment of the FIFO head
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        head_strb       = 4'b1111;
        head_wdata      = head.data;
        head_misaligned = 1'b0;
        case (head.size)
            2'b00: begin
                head_strb  = 4'b0001 << head.addr[1:0];
                head_wdata = {4{head.data[7:0]}};
            end
            2'b01: begin
                head_strb       = 4'b0011 << {head.addr[1], 1'b0};
                head_wdata      = {2{head.data[15:0]}};
                head_misaligned = head.addr[0];
            end
            default: begin
                // Size code 2'b11 is treated as a word store.
                head_misaligned = (head.addr[1:0] != 2'b00);
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    // A misaligned head is consumed without issuing anything.
                    if (!head_misaligned) begin
                        load      = 1'b1;
                        state_nxt = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (bus.m_awready && bus.m_wready) state_nxt = S_RESP;
                else if (bus.m_awready)            state_nxt = S_WAIT_W;
                else if (bus.m_wready)             state_nxt = S_WAIT_AW;
            end
            S_WAIT_AW: if (bus.m_awready) state_nxt = S_RESP;
            S_WAIT_W:  if (bus.m_wready)  state_nxt = S_RESP;
            S_RESP:    if (bus.m_bvalid)  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Channel controls are registered copies of the next-state decode, so each valid
    // stays high exactly until its own handshake and the payload only changes on load.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            awvalid_q <= (state_nxt == S_ADDR) || (state_nxt == S_WAIT_AW);
            wvalid_q  <= (state_nxt == S_ADDR) || (state_nxt == S_WAIT_W);
            bready_q  <= (state_nxt == S_RESP);
            if (load) begin
                awaddr_q <= head.addr;
                wdata_q  <= head_wdata;
                wstrb_q  <= head_strb;
            end
        end
    end

    assign bus.m_awvalid = awvalid_q;
    assign bus.m_awaddr  = awaddr_q;
    assign bus.m_awprot  = 3'b000;
    assign bus.m_wvalid  = wvalid_q;
    assign bus.m_wdata   = wdata_q;
    assign bus.m_wstrb   = wstrb_q;
    assign bus.m_bready  = bready_q;

    // ------------------------------------------------------------------
    // Error reporting
    // ------------------------------------------------------------------
`ifdef MMIO_STORE_ERR_EN
    logic err_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else if ((bus.m_bvalid && bready_q && bus.m_bresp[1]) || (pop && !load)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

    // funct3[2] (signedness) means nothing to a store; bresp is only consulted with errors enabled.
    logic unused_bits;
    assign unused_bits = ^{req_funct3[2], bus.m_bresp};

endmodule

// File: tb/tb_mmio_store_ctrl.sv
// Self-checking bench for mmio_store_ctrl: directed cases from the store/AXI rules plus a random run,
// all compared each cycle against a queue-based transaction model.
module tb_mmio_store_ctrl;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_funct3;
    logic        req_ready;
    logic        stall;
    logic        idle;
`ifdef MMIO_STORE_ERR_EN
    logic        err;
`endif

    mmio_store_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mmio_store_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_funct3 (req_funct3),
        .req_ready  (req_ready),
        .stall      (stall),
        .idle       (idle),
`ifdef MMIO_STORE_ERR_EN
        .err        (err),
`endif
        .bus        (bus.master)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  f3;
    } store_t;

    store_t      q[$];
    store_t      m_head;
    bit          m_push;
    bit          busy;
    bit          exp_awvalid;
    bit          exp_wvalid;
    bit          exp_bready;
    bit          exp_err;
    logic [31:0] exp_awaddr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    bit          cmp_en = 1'b0;

    function automatic int unsigned size_of(input logic [1:0] f);
        return (f == 2'd0) ? 1 : (f == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit misaligned(input store_t s);
        return (s.addr % size_of(s.f3)) != 0;
    endfunction

    function automatic logic [3:0] strb_of(input store_t s);
        int unsigned n;
        n = size_of(s.f3);
        return 4'(((1 << n) - 1) << (s.addr % 4));
    endfunction

    function automatic logic [31:0] lanes_of(input store_t s);
        case (size_of(s.f3))
            1:       return (s.data & 32'h0000_00FF) * 32'h0101_0101;
            2:       return (s.data & 32'h0000_FFFF) * 32'h0001_0001;
            default: return s.data;
        endcase
    endfunction

    always @(posedge aclk) begin
        if (!aresetn) begin
            q.delete();
            busy        = 1'b0;
            exp_awvalid = 1'b0;
            exp_wvalid  = 1'b0;
            exp_bready  = 1'b0;
            exp_err     = 1'b0;
            exp_awaddr  = '0;
            exp_wdata   = '0;
            exp_wstrb   = '0;
        end else begin
            m_push = req_valid && (q.size() < DEPTH);
            if (busy) begin
                if (exp_bready) begin
                    if (bus.m_bvalid) begin
                        busy       = 1'b0;
                        exp_bready = 1'b0;
                        if (bus.m_bresp[1]) exp_err = 1'b1;
                    end
                end else begin
                    if (exp_awvalid && bus.m_awready) exp_awvalid = 1'b0;
                    if (exp_wvalid && bus.m_wready)   exp_wvalid  = 1'b0;
                    if (!exp_awvalid && !exp_wvalid)  exp_bready  = 1'b1;
                end
            end else if (q.size() > 0) begin
                m_head = q.pop_front();
                if (misaligned(m_head)) begin
                    exp_err = 1'b1;
                end else begin
                    busy        = 1'b1;
                    exp_awvalid = 1'b1;
                    exp_wvalid  = 1'b1;
                    exp_awaddr  = m_head.addr;
                    exp_wdata   = lanes_of(m_head);
                    exp_wstrb   = strb_of(m_head);
                end
            end
            if (m_push) q.push_back('{addr: req_addr, data: req_data, f3: req_funct3[1:0]});
        end
    end

    // Every cycle, away from the active edge, the DUT must agree with the model.
    always @(negedge aclk) begin
        if (cmp_en) begin
            check("awvalid",   32'(bus.m_awvalid), 32'(exp_awvalid));
            check("wvalid",    32'(bus.m_wvalid),  32'(exp_wvalid));
            check("bready",    32'(bus.m_bready),  32'(exp_bready));
            check("awaddr",    bus.m_awaddr,       exp_awaddr);
            check("wdata",     bus.m_wdata,        exp_wdata);
            check("wstrb",     32'(bus.m_wstrb),   32'(exp_wstrb));
            check("awprot",    32'(bus.m_awprot),  32'd0);
            check("req_ready", 32'(req_ready),     32'(q.size() < DEPTH));
            check("stall",     32'(stall),         32'(req_valid && (q.size() >= DEPTH)));
            check("idle",      32'(idle),          32'(!busy && (q.size() == 0)));
`ifdef MMIO_STORE_ERR_EN
            check("err",       32'(err),           32'(exp_err));
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [31:0] hs_addr[$];

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        req_valid  = 1'b1;
        req_addr   = a;
        req_data   = d;
        req_funct3 = f;
    endtask

    // Acts as the AXI slave (and optionally a random memory stage) for a bounded number of cycles.
    task automatic serve(input int cycles, input int p_aw, input int p_w, input int p_b,
                         input int p_req, input int p_err);
        bit aw_hs;
        bit b_hs;
        for (int c = 0; c < cycles; c++) begin
            bus.m_awready = ($urandom_range(99) < p_aw);
            bus.m_wready  = ($urandom_range(99) < p_w);
            if (!bus.m_bvalid && bus.m_bready && ($urandom_range(99) < p_b)) begin
                bus.m_bvalid = 1'b1;
                bus.m_bresp  = ($urandom_range(99) < p_err) ? 2'b10 : 2'b00;
            end
            if ($urandom_range(99) < p_req) begin
                push_store(32'h1000 + 32'($urandom_range(255)), $urandom, 3'($urandom_range(7)));
            end else begin
                req_valid = 1'b0;
            end
            aw_hs = bus.m_awvalid && bus.m_awready;
            b_hs  = bus.m_bvalid && bus.m_bready;
            if (aw_hs) hs_addr.push_back(bus.m_awaddr);
            step();
            if (b_hs) begin
                bus.m_bvalid = 1'b0;
                bus.m_bresp  = 2'b00;
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int n_acc;

    initial begin
        aresetn       = 1'b0;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_data      = '0;
        req_funct3    = '0;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_bvalid  = 1'b0;
        bus.m_bresp   = 2'b00;
        step();
        step();

        // Reset state
        check("rst_awvalid",   32'(bus.m_awvalid), 32'd0);
        check("rst_wvalid",    32'(bus.m_wvalid),  32'd0);
        check("rst_bready",    32'(bus.m_bready),  32'd0);
        check("rst_awaddr",    bus.m_awaddr,       32'd0);
        check("rst_wdata",     bus.m_wdata,        32'd0);
        check("rst_wstrb",     32'(bus.m_wstrb),   32'd0);
        check("rst_req_ready", 32'(req_ready),     32'd1);
        check("rst_stall",     32'(stall),         32'd0);
        check("rst_idle",      32'(idle),          32'd1);
`ifdef MMIO_STORE_ERR_EN
        check("rst_err",       32'(err),           32'd0);
`endif
        aresetn = 1'b1;
        cmp_en  = 1'b1;

        // Single byte store: valids in N+2 for one cycle, B one cycle after the handshake.
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        push_store(32'h0000_00FF, 32'h41, 3'b000);
        step();
        req_valid = 1'b0;
        check("sb_idle_n1",    32'(idle),          32'd0);
        check("sb_awvalid_n1", 32'(bus.m_awvalid), 32'd0);
        step();
        check("sb_awvalid_n2", 32'(bus.m_awvalid), 32'd1);
        check("sb_wvalid_n2",  32'(bus.m_wvalid),  32'd1);
        check("sb_awaddr",     bus.m_awaddr,       32'h0000_00FF);
        check("sb_wstrb",      32'(bus.m_wstrb),   32'b1000);
        check("sb_wdata",      bus.m_wdata,        32'h4141_4141);
        step();
        check("sb_awvalid_n3", 32'(bus.m_awvalid), 32'd0);
        check("sb_bready_n3",  32'(bus.m_bready),  32'd1);
        bus.m_bvalid = 1'b1;
        step();
        bus.m_bvalid = 1'b0;
        check("sb_bready_n4",  32'(bus.m_bready),  32'd0);
        check("sb_idle_n4",    32'(idle),          32'd1);

        // Back-pressure: 6 back-to-back stores, DEPTH buffered plus one in flight.
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            push_store(32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i), 3'b010);
            #1;
            if (req_ready) n_acc++;
            if (i == 5) begin
                check("bp_ready_6th", 32'(req_ready), 32'd0);
                check("bp_stall_6th", 32'(stall),     32'd1);
            end
            step();
        end
        req_valid = 1'b0;
        check("bp_accepted", 32'(n_acc), 32'd5);
        hs_addr.delete();
        serve(40, 100, 100, 100, 0, 0);
        check("bp_drained", 32'(hs_addr.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < hs_addr.size()) check("bp_order", hs_addr[i], 32'h200 + 32'(4 * i));
        end

        // Split handshake: AW taken in ADDR, W three cycles later.
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        push_store(32'h100, 32'hDEAD_BEEF, 3'b010);
        step();
        req_valid = 1'b0;
        step();
        check("split_awvalid_addr", 32'(bus.m_awvalid), 32'd1);
        check("split_wvalid_addr",  32'(bus.m_wvalid),  32'd1);
        bus.m_awready = 1'b1;
        step();
        bus.m_awready = 1'b0;
        check("split_aw_dropped", 32'(bus.m_awvalid), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            check("split_wvalid_held", 32'(bus.m_wvalid), 32'd1);
            check("split_wdata_held",  bus.m_wdata,       32'hDEAD_BEEF);
            check("split_bready_low",  32'(bus.m_bready), 32'd0);
            if (c == 3) bus.m_wready = 1'b1;
            step();
        end
        bus.m_wready = 1'b0;
        check("split_wvalid_done", 32'(bus.m_wvalid), 32'd0);
        check("split_bready_up",   32'(bus.m_bready), 32'd1);
        bus.m_bvalid = 1'b1;
        step();
        bus.m_bvalid = 1'b0;

        // Halfword in the upper lanes.
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        push_store(32'h102, 32'h0000_BEEF, 3'b001);
        step();
        req_valid = 1'b0;
        step();
        check("sh_awaddr", bus.m_awaddr,     32'h102);
        check("sh_wstrb",  32'(bus.m_wstrb), 32'b1100);
        check("sh_wdata",  bus.m_wdata,      32'hBEEF_BEEF);
        step();
        bus.m_bvalid = 1'b1;
        step();
        bus.m_bvalid = 1'b0;

        // Reset while waiting on W with two entries queued.
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_store(32'h300 + 32'(4 * i), 32'h5500_0000 + 32'(i), 3'b010);
            step();
        end
        req_valid = 1'b0;
        check("rif_wvalid_pending", 32'(bus.m_wvalid), 32'd1);
        check("rif_idle_busy",      32'(idle),         32'd0);
        aresetn       = 1'b0;
        bus.m_awready = 1'b0;
        step();
        aresetn = 1'b1;
        check("rif_awvalid", 32'(bus.m_awvalid), 32'd0);
        check("rif_wvalid",  32'(bus.m_wvalid),  32'd0);
        check("rif_ready",   32'(req_ready),     32'd1);
        check("rif_idle",    32'(idle),          32'd1);
        hs_addr.delete();
        serve(20, 100, 100, 100, 0, 0);
        check("rif_no_more_tx", 32'(hs_addr.size()), 32'd0);

`ifdef MMIO_STORE_ERR_EN
        // Error response sets err and it stays set.
        bus.m_awready = 1'b1;
        bus.m_wready  = 1'b1;
        push_store(32'h400, 32'h1234_5678, 3'b010);
        step();
        req_valid = 1'b0;
        step();
        step();
        bus.m_bvalid = 1'b1;
        bus.m_bresp  = 2'b10;
        step();
        bus.m_bvalid = 1'b0;
        bus.m_bresp  = 2'b00;
        check("err_on_slverr", 32'(err), 32'd1);
        push_store(32'h404, 32'h0, 3'b010);
        step();
        req_valid = 1'b0;
        serve(10, 100, 100, 100, 0, 0);
        check("err_sticky", 32'(err), 32'd1);
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        check("err_cleared", 32'(err), 32'd0);
`endif

        // Misaligned word store is discarded with no AXI activity.
        hs_addr.delete();
        push_store(32'h101, 32'hCAFE_F00D, 3'b010);
        step();
        req_valid = 1'b0;
        serve(10, 100, 100, 100, 0, 0);
        check("misaligned_no_tx", 32'(hs_addr.size()), 32'd0);
`ifdef MMIO_STORE_ERR_EN
        check("misaligned_err", 32'(err), 32'd1);
`endif

        // Random traffic against the model, then drain.
        serve(3000, 60, 60, 60, 50, 10);
        serve(200, 100, 100, 100, 0, 0);
        check("final_idle", 32'(idle), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
